// File: rtl/fir_datapath_mc.sv
// Multi-channel FIR datapath: NB_CH round-robin interleaved channels share one
// serially loaded coefficient set. Each channel has its own delay line. The
// output is round-shifted, saturated and tagged with its channel index.
module fir_mc_mul #(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] p
);
  // One signed tap product at full precision
  assign p = $signed(a) * $signed(b);
endmodule

module fir_datapath_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int NB_TAPS    = 8,
  parameter int NB_CH      = 4,
  parameter int SHIFT      = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  input  logic                  h_valid_i,
  output logic                  h_ready_o,
  input  logic [DATA_WIDTH-1:0] h_data_i,
  output logic                  y_valid_o,
  input  logic                  y_ready_i,
  output logic [DATA_WIDTH-1:0] y_data_o,
  output logic [((NB_CH > 1) ? $clog2(NB_CH) : 1)-1:0] y_ch_o,
  output logic                  busy_o
);
  localparam int DW    = DATA_WIDTH;
  localparam int CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int TAP_W = $clog2(NB_TAPS);
  localparam int ACC_W = 2*DW + TAP_W;

  // Half-LSB rounding constant; collapses to zero when SHIFT is 0.
  localparam logic signed [ACC_W:0] RND     = ((ACC_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_e;

  state_e                                  state, state_nxt;
  logic [TAP_W-1:0]                        tap_cnt;
  logic [CH_W-1:0]                         ch_cnt;
  logic [NB_TAPS-1:0][DW-1:0]              coef;
  logic [NB_CH-1:0][NB_TAPS-2:0][DW-1:0]   dl;
  logic [NB_TAPS-1:0][DW-1:0]              tap_x;
  logic [NB_TAPS-1:0][2*DW-1:0]            prod;
  logic signed [ACC_W-1:0]                 acc;
  logic signed [ACC_W:0]                   rnd, r;
  logic [DW-1:0]                           y_nxt;
  logic                                    h_fire, x_fire, tap_last, ch_last;

  assign h_fire   = h_valid_i && h_ready_o;
  assign x_fire   = x_valid_i && x_ready_o;
  assign tap_last = (tap_cnt == TAP_W'(NB_TAPS-1));
  assign ch_last  = (ch_cnt == CH_W'(NB_CH-1));

  // FSM state register; reset and clear both return to coefficient load
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state <= S_LOAD;
    else                  state <= state_nxt;
  end

  // FSM next state: the last coefficient beat starts streaming; RUN is sticky
  always_comb begin
    state_nxt = state;
    if (state == S_LOAD && h_fire && tap_last) state_nxt = S_RUN;
  end

  // FSM outputs: x is accepted only when the output register can take it
  always_comb begin
    h_ready_o = (state == S_LOAD);
    busy_o    = (state == S_RUN);
    x_ready_o = (state == S_RUN) && (!y_valid_o || y_ready_i);
  end

  // Tap operands: newest sample on tap 0, then the current channel's history
  assign tap_x[0] = x_data_i;
  for (genvar k = 1; k < NB_TAPS; k++) begin : g_tap
    assign tap_x[k] = dl[ch_cnt][k-1];
  end

  for (genvar k = 0; k < NB_TAPS; k++) begin : g_mul
    fir_mc_mul #(.DW(DW)) u_mul (.a(tap_x[k]), .b(coef[k]), .p(prod[k]));
  end

  // Accumulate sign-extended products; ACC_W has enough headroom for NB_TAPS terms
  always_comb begin
    acc = '0;
    for (int k = 0; k < NB_TAPS; k++) acc = acc + ACC_W'($signed(prod[k]));
  end

  // Round half up, arithmetic shift, then clip to the output range
  always_comb begin
    rnd = (ACC_W+1)'(acc) + RND;
    r   = rnd >>> SHIFT;
    if (r > SAT_MAX)      y_nxt = {1'b0, {(DW-1){1'b1}}};
    else if (r < SAT_MIN) y_nxt = {1'b1, {(DW-1){1'b0}}};
    else                  y_nxt = r[DW-1:0];
  end

  // Coefficient load, per-channel delay lines and the output register
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      tap_cnt   <= '0;
      ch_cnt    <= '0;
      coef      <= '0;
      dl        <= '0;
      y_valid_o <= 1'b0;
      y_data_o  <= '0;
      y_ch_o    <= '0;
    end else begin
      if (h_fire) begin
        coef[tap_cnt] <= h_data_i;
        tap_cnt       <= tap_last ? '0 : tap_cnt + 1'b1;
      end
      if (x_fire) begin
        for (int k = NB_TAPS-2; k > 0; k--) dl[ch_cnt][k] <= dl[ch_cnt][k-1];
        dl[ch_cnt][0] <= x_data_i;
        y_valid_o     <= 1'b1;
        y_data_o      <= y_nxt;
        y_ch_o        <= ch_cnt;
        ch_cnt        <= ch_last ? '0 : ch_cnt + 1'b1;
      end else if (y_ready_i) begin
        y_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fir_datapath_mc.sv
// Bench for fir_datapath_mc: directed scenarios plus randomized streaming,
// checked against an arithmetic per-channel FIR model.
module tb_fir_datapath_mc;
  localparam int DW = 16, NT = 8, NC = 4, SH = 15;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  logic clk = 1'b0;
  logic rst_i, clear_i, x_valid_i, x_ready_o, h_valid_i, h_ready_o;
  logic y_valid_o, y_ready_i, busy_o;
  logic [DW-1:0] x_data_i, h_data_i, y_data_o;
  logic [CW-1:0] y_ch_o;

  fir_datapath_mc #(.DATA_WIDTH(DW), .NB_TAPS(NT), .NB_CH(NC), .SHIFT(SH)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
    .h_valid_i(h_valid_i), .h_ready_o(h_ready_o), .h_data_i(h_data_i),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_data_o(y_data_o),
    .y_ch_o(y_ch_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int xq[$], exp_d[$], exp_c[$], got_d[$], got_c[$];
  int viol, unstable, last_cycles;
  bit timeout;
  int hset[NT];

  // Reference model: coefficients, newest-first history per channel, next channel
  int m_h[NT];
  int m_hist[NC][NT];
  int m_ch;

  function automatic void model_clear();
    m_ch = 0;
    for (int i = 0; i < NT; i++) m_h[i] = 0;
    for (int c = 0; c < NC; c++) for (int i = 0; i < NT; i++) m_hist[c][i] = 0;
  endfunction

  function automatic void model_push(input int x, output int y, output int ch);
    longint acc, r;
    acc = longint'(x) * m_h[0];
    for (int k = 1; k < NT; k++) acc += longint'(m_hist[m_ch][k-1]) * m_h[k];
    for (int k = NT-1; k > 0; k--) m_hist[m_ch][k] = m_hist[m_ch][k-1];
    m_hist[m_ch][0] = x;
    r = (acc + ((SH > 0) ? (longint'(1) << (SH-1)) : longint'(0))) >>> SH;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    y = int'(r);
    ch = m_ch;
    m_ch = (m_ch + 1) % NC;
  endfunction

  function automatic void model_fill();
    int y, ch;
    exp_d.delete(); exp_c.delete();
    foreach (xq[i]) begin
      model_push(xq[i], y, ch);
      exp_d.push_back(y); exp_c.push_back(ch);
    end
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; clear_i = 1'b0; x_valid_i = 1'b0; h_valid_i = 1'b0;
    y_ready_i = 1'b0; x_data_i = '0; h_data_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_clear();
  endtask

  // Coefficient beats on consecutive edges; x_valid is held high to show it is ignored in LOAD
  task automatic load_coefs(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      h_valid_i = 1'b1; h_data_i = DW'(hset[i]);
      x_valid_i = 1'b1; x_data_i = 16'h1357;
      #1;
      if (!h_ready_o) begin
        checks++; failures++;
        $display("FAIL load_ready beat=%0d h_ready_o=%0b required=1", i, h_ready_o);
      end
      m_h[i] = hset[i];
      @(posedge clk);
    end
    @(negedge clk);
    h_valid_i = 1'b0; x_valid_i = 1'b0;
    #1;
  endtask

  // Push every xq entry with random valid/ready, collecting all popped outputs
  task automatic drive_stream(input int xprob, input int yprob);
    int idx = 0, cyc = 0, idle = 0, hold_d = 0, hold_c = 0;
    bit pend = 0, hold = 0;
    got_d.delete(); got_c.delete();
    viol = 0; unstable = 0; timeout = 0;
    while (1) begin
      @(negedge clk);
      if (!pend) begin
        x_valid_i = (idx < xq.size()) && ($urandom_range(0, 99) < xprob);
        if (x_valid_i) x_data_i = DW'(xq[idx]);
      end
      y_ready_i = ($urandom_range(0, 99) < yprob);
      #1;
      if (hold && (!y_valid_o || $signed(y_data_o) != hold_d || int'(y_ch_o) != hold_c)) unstable++;
      if (y_valid_o && !y_ready_i && x_ready_o) viol++;
      hold = y_valid_o && !y_ready_i;
      hold_d = $signed(y_data_o); hold_c = int'(y_ch_o);
      if (y_valid_o && y_ready_i) begin
        got_d.push_back($signed(y_data_o)); got_c.push_back(int'(y_ch_o));
      end
      pend = x_valid_i && !x_ready_o;
      if (x_valid_i && x_ready_o) idx++;
      cyc++;
      if (idx == xq.size() && got_d.size() >= xq.size()) idle++;
      if (idle >= 3) break;
      if (cyc > 20 * xq.size() + 100) begin timeout = 1; break; end
    end
    last_cycles = cyc - 3;
    @(negedge clk);
    x_valid_i = 1'b0; y_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (y_valid_o !== 1'b0 || y_data_o !== '0 || y_ch_o !== '0 || busy_o !== 1'b0 ||
        h_ready_o !== 1'b1 || x_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state yv=%0b yd=%0h ych=%0d busy=%0b hr=%0b xr=%0b required 0,0,0,0,1,0",
               y_valid_o, y_data_o, y_ch_o, busy_o, h_ready_o, x_ready_o);
    end
    x_valid_i = 1'b1; x_data_i = 16'h7fff;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (x_ready_o !== 1'b0 || y_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL x_in_load x_ready=%0b y_valid=%0b required 0,0", x_ready_o, y_valid_o);
    end
    x_valid_i = 1'b0;
  endtask

  // x = 32767 (just under 1.0) on ch0 followed by zeros: ch0 reproduces h = 1..8 then 0
  task automatic test_impulse();
    int e;
    do_reset();
    for (int i = 0; i < NT; i++) hset[i] = i + 1;
    load_coefs(0, NT);
    xq.delete();
    for (int i = 0; i < 4 * (NT + 1); i++) xq.push_back((i == 0) ? 32767 : 0);
    drive_stream(100, 100);
    checks++;
    if (timeout || got_d.size() != xq.size()) begin
      failures++;
      $display("FAIL impulse_count got=%0d required=%0d timeout=%0b", got_d.size(), xq.size(), timeout);
    end
    for (int i = 0; i < got_d.size() && i < xq.size(); i++) begin
      e = (i % 4 == 0 && i / 4 < NT) ? i / 4 + 1 : 0;
      checks++;
      if (got_d[i] != e || got_c[i] != i % 4) begin
        failures++;
        $display("FAIL impulse idx=%0d got=%0d/ch%0d required=%0d/ch%0d", i, got_d[i], got_c[i], e, i % 4);
      end
    end
    checks++;
    if (last_cycles > xq.size() + 2) begin
      failures++;
      $display("FAIL back_to_back cycles=%0d required<=%0d", last_cycles, xq.size() + 2);
    end
  endtask

  // h0 = h1 = 0.5: each channel averages its own last two samples
  task automatic test_channel_isolation();
    int lit[8] = '{5, 10, 15, 20, 6, 11, 17, 22};
    do_reset();
    for (int i = 0; i < NT; i++) hset[i] = (i < 2) ? 16384 : 0;
    load_coefs(0, NT);
    xq = '{10, 20, 30, 40, 1, 2, 3, 4};
    drive_stream(80, 70);
    checks++;
    if (timeout || got_d.size() != 8) begin
      failures++;
      $display("FAIL isolation_count got=%0d required=8 timeout=%0b", got_d.size(), timeout);
    end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      checks++;
      if (got_d[i] != lit[i] || got_c[i] != i % 4) begin
        failures++;
        $display("FAIL isolation idx=%0d got=%0d/ch%0d required=%0d/ch%0d", i, got_d[i], got_c[i], lit[i], i % 4);
      end
    end
  endtask

  // Full-scale coefficients: positive ramp 32766 then clips at 32767, negative clips at -32768
  task automatic test_saturation();
    int e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < NT; i++) hset[i] = (pass == 0) ? 32767 : -32768;
      load_coefs(0, NT);
      xq.delete();
      for (int i = 0; i < 4 * NT; i++) xq.push_back((i % 4 == 0) ? 32767 : 0);
      drive_stream(100, 60);
      checks++;
      if (timeout || got_d.size() != xq.size()) begin
        failures++;
        $display("FAIL sat_count pass=%0d got=%0d required=%0d", pass, got_d.size(), xq.size());
      end
      for (int i = 0; i < got_d.size() && i < xq.size(); i++) begin
        if (i % 4 != 0) e = 0;
        else if (pass == 0) e = (i == 0) ? 32766 : 32767;
        else e = (i == 0) ? -32767 : -32768;
        checks++;
        if (got_d[i] != e) begin
          failures++;
          $display("FAIL saturation pass=%0d idx=%0d got=%0d required=%0d", pass, i, got_d[i], e);
        end
      end
    end
  endtask

  // Random data and coefficients, random valid/ready, h_valid held high in RUN
  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < NT; i++) hset[i] = rnd16();
    load_coefs(0, NT);
    xq.delete();
    for (int i = 0; i < 512; i++) xq.push_back(rnd16());
    model_fill();
    h_valid_i = 1'b1; h_data_i = 16'h4000;
    #1;
    checks++;
    if (h_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL h_in_run h_ready=%0b required=0", h_ready_o);
    end
    drive_stream(70, 50);
    h_valid_i = 1'b0;
    checks++;
    if (timeout || got_d.size() != exp_d.size()) begin
      failures++;
      $display("FAIL bp_count got=%0d required=%0d timeout=%0b", got_d.size(), exp_d.size(), timeout);
    end
    checks++;
    if (viol != 0 || unstable != 0) begin
      failures++;
      $display("FAIL bp_protocol accept_while_stalled=%0d unstable=%0d required 0,0", viol, unstable);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_c[i] != exp_c[i]) begin
        failures++;
        $display("FAIL bp_data idx=%0d got=%0d/ch%0d required=%0d/ch%0d", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < NT; i++) hset[i] = rnd16();
    load_coefs(0, NT);
    xq.delete();
    for (int i = 0; i < 5; i++) xq.push_back(rnd16());
    drive_stream(100, 100);
    // leave a pending output in the register, then clear
    @(negedge clk);
    x_valid_i = 1'b1; x_data_i = 16'd1234; y_ready_i = 1'b0;
    @(negedge clk);
    x_valid_i = 1'b0; clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || h_ready_o !== 1'b1 || y_valid_o !== 1'b0 || y_data_o !== '0 || y_ch_o !== '0) begin
      failures++;
      $display("FAIL clear_state busy=%0b hr=%0b yv=%0b yd=%0h ych=%0d required 0,1,0,0,0",
               busy_o, h_ready_o, y_valid_o, y_data_o, y_ch_o);
    end
    model_clear();
    for (int i = 0; i < NT; i++) hset[i] = rnd16();
    load_coefs(0, NT);
    xq.delete();
    for (int i = 0; i < 12; i++) xq.push_back(rnd16());
    model_fill();
    drive_stream(90, 80);
    checks++;
    if (timeout || got_d.size() != exp_d.size()) begin
      failures++;
      $display("FAIL clear_count got=%0d required=%0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_c[i] != exp_c[i]) begin
        failures++;
        $display("FAIL clear_restart idx=%0d got=%0d/ch%0d required=%0d/ch%0d", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    for (int i = 0; i < NT; i++) hset[i] = 30000 - i;
    load_coefs(0, 3);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_clear();
    #1;
    checks++;
    if (busy_o !== 1'b0 || h_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL midload_reset busy=%0b hr=%0b required 0,1", busy_o, h_ready_o);
    end
    for (int i = 0; i < NT; i++) hset[i] = rnd16();
    load_coefs(0, NT - 1);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL midload_7beats busy=%0b required=0", busy_o);
    end
    load_coefs(NT - 1, 1);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL midload_8beats busy=%0b required=1", busy_o);
    end
    xq.delete();
    for (int i = 0; i < 16; i++) xq.push_back(rnd16());
    model_fill();
    drive_stream(100, 100);
    checks++;
    if (timeout || got_d.size() != exp_d.size()) begin
      failures++;
      $display("FAIL midload_count got=%0d required=%0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_c[i] != exp_c[i]) begin
        failures++;
        $display("FAIL midload_data idx=%0d got=%0d/ch%0d required=%0d/ch%0d", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_channel_isolation();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
